seq_lookahead_subtractor: RTL

Multi-cycle 32-bit subtractor computing diff = a - b - bin, one 8-bit borrow-lookahead slice per cycle.
- It is the inverse-direction companion of the datapath's 32-bit carry-lookahead adder.
- It serves ALU paths that can tolerate latency in exchange for a small area.
- It uses a start/busy/done handshake and holds its result until the next operation is accepted.

---
 rtl/arith_pkg.sv | 13 +
 rtl/borrow_lookahead_slice.sv | 50 +++++
 rtl/seq_lookahead_subtractor.sv | 117 +++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: subtractor FSM state encoding and default widths.
package arith_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int SLICE_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/borrow_lookahead_slice.sv
// Combinational SLICE_W-bit borrow-lookahead subtract slice (d = a - b - bin), zero latency.
// Every borrow is a flat sum-of-products of generate/propagate terms and bin_s, with no ripple.
module borrow_lookahead_slice
    import arith_pkg::*;
#(
    parameter int SLICE_W = SLICE_W_DEF
) (
    input  logic [SLICE_W-1:0] a_s,
    input  logic [SLICE_W-1:0] b_s,
    input  logic               bin_s,
    output logic [SLICE_W-1:0] d_s,
    output logic               bout_s
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:0]   bor;
    logic               acc;
    logic               term;

    assign g = ~a_s & b_s;
    assign p = ~(a_s ^ b_s);

    // bor[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]bin_s
    always_comb begin
        bor    = '0;
        bor[0] = bin_s;
        acc    = 1'b0;
        term   = 1'b0;
        for (int i = 0; i < SLICE_W; i++) begin
            term = bin_s;
            for (int k = 0; k <= i; k++) begin
                term = term & p[k];
            end
            acc = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                acc = acc | term;
            end
            bor[i+1] = acc;
        end
    end

    assign d_s    = a_s ^ b_s ^ bor[SLICE_W-1:0];
    assign bout_s = bor[SLICE_W];

endmodule

// File: rtl/seq_lookahead_subtractor.sv
// Multi-cycle a - b - bin, one lookahead slice per cycle; done pulses WIDTH/SLICE_W+1 edges after start.
// start is ignored while busy; the result holds until the next accepted start. SUB_OVF_EN adds ovf.
module seq_lookahead_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SLICE_W = SLICE_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NUM_SLICES = WIDTH / SLICE_W;
    localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               brw_q;
    logic [WIDTH-1:0]   diff_q;
    logic               borrow_q;

    logic [SLICE_W-1:0] a_slc;
    logic [SLICE_W-1:0] b_slc;
    logic [SLICE_W-1:0] d_slc;
    logic               bout_slc;
    logic               last_slc;
    logic               accept;

    // DONE accepts a new start just like IDLE, enabling back-to-back operations.
    assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_slc = (cnt_q == CNT_W'(NUM_SLICES - 1));

    assign a_slc = a_q[cnt_q*SLICE_W +: SLICE_W];
    assign b_slc = b_q[cnt_q*SLICE_W +: SLICE_W];

    borrow_lookahead_slice #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .a_s    (a_slc),
        .b_s    (b_slc),
        .bin_s  (brw_q),
        .d_s    (d_slc),
        .bout_s (bout_slc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = accept ? RUN : IDLE;
            RUN:        state_d = last_slc ? DONE : RUN;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            brw_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                brw_q <= bin;
                cnt_q <= '0;
            end else if (state_q == RUN) begin
                diff_q[cnt_q*SLICE_W +: SLICE_W] <= d_slc;
                brw_q <= bout_slc;
                cnt_q <= cnt_q + 1'b1;
                if (last_slc) begin
                    borrow_q <= bout_slc;
                end
            end
        end
    end

`ifdef SUB_OVF_EN
    logic ovf_q;

    // Final diff MSB is the top bit of the last slice, available in the same cycle it is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN && last_slc && !accept) begin
            ovf_q <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (d_slc[SLICE_W-1] ^ a_q[WIDTH-1]);
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule
